// File: rtl/btn_pkg.sv
// Shared constants for the pushbutton conditioner: channel
// index map and default debounce / auto-repeat timing.
package btn_pkg;

  localparam int N_BTN_DEF = 4;

  localparam int BTN_START = 0;
  localparam int BTN_PAUSE = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

  localparam int DEBOUNCE_DEF     = 1_000_000;
  localparam int REPEAT_DELAY_DEF = 40_000_000;
  localparam int REPEAT_RATE_DEF  = 10_000_000;

  localparam logic [N_BTN_DEF-1:0] REPEAT_MASK_DEF =
    (N_BTN_DEF'(1) << BTN_LEFT) |
    (N_BTN_DEF'(1) << BTN_RIGHT);

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bundle between the pins side and the conditioner:
// raw pins in, debounced level and press/release pulses out.
interface btn_conditioner_if #(
  parameter int N_BTN = btn_pkg::N_BTN_DEF
);

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );

endinterface

// File: rtl/debounce_ch.sv
// One button channel: 2-FF sync, counter debounce, edge pulses.
// Optional auto-repeat on held press under AUTOREPEAT_EN.
module debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE     = REPEAT_RATE_DEF,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          rep;

  assign accept = (s2 != level) &&
                  (cnt == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= (accept && s2) || rep;
      rel   <= accept && !s2;
      if (s2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef AUTOREPEAT_EN
  if (REPEAT_EN) begin : g_rep
    localparam int RW = $clog2(REPEAT_DELAY);

    logic [RW-1:0] rc;

    // accept while level is high is a release: suppress the repeat
    assign rep = level && !accept &&
                 (rc == RW'(REPEAT_DELAY - 1));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rc <= '0;
      end else if (!level || accept) begin
        rc <= '0;
      end else if (rep) begin
        rc <= RW'(REPEAT_DELAY - REPEAT_RATE);
      end else begin
        rc <= rc + RW'(1);
      end
    end
  end else begin : g_norep
    assign rep = 1'b0;
  end
`else
  assign rep = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// Conditions raw pushbuttons into clean levels and edge pulses.
// Define AUTOREPEAT_EN to enable auto-repeat on REPEAT_MASK channels.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int               N_BTN           = N_BTN_DEF,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int               REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int               REPEAT_RATE     = REPEAT_RATE_DEF,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = REPEAT_MASK_DEF
) (
  input logic         clk,
  input logic         rst,
  btn_conditioner_if.slave bus
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .raw   (bus.btn_raw[i]),
      .level (bus.btn_level[i]),
      .press (bus.btn_press[i]),
      .rel   (bus.btn_release[i])
    );
  end

endmodule
